mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch requester and the

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_sat.sv | 37 +++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types for the unified-memory arbiter of the rv32I core.
//   - arb_state_t : arbiter FSM states (IDLE, WAIT_RSP)
//   - arb_owner_t : which requester owns / is granted the memory port
//   - STARVE_W    : width of the fetch starvation counter
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE,
        WAIT_RSP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_sat.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that saturates at MAX and clears synchronously. Used as the
//   fetch starvation counter of mem_arbiter.
// Ports:
//   clk     in   clock, rising edge
//   reset_n in   asynchronous active-low reset (count -> 0)
//   inc     in   increment request (ignored once count == MAX)
//   clr     in   synchronous clear, wins over inc
//   count   out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < MAX_V)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch (if_*) and
//   load/store (d_*) requesters. One transaction outstanding at a time. Data
//   wins arbitration unless fetch has lost MAX_WAIT times in a row.
//
// Optional feature: define MEM_ARB_PERF_EN to add perf_if_grants,
//   perf_d_grants and perf_stall_cycles (32-bit, wrapping) outputs.
//
// Ports:
//   clk, reset_n                          clock / async active-low reset
//   if_req_valid/ready, if_addr           fetch request channel
//   if_rsp_valid, if_rdata                fetch response (1-cycle pulse)
//   d_req_valid/ready, d_addr, d_we,
//   d_wdata                               data request channel
//   d_rsp_valid, d_rdata                  data response (1-cycle pulse)
//   mem_req_valid/ready, mem_addr,
//   mem_we, mem_wdata                     request to memory
//   mem_rsp_valid, mem_rdata              response from memory
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam logic [STARVE_W-1:0] MAX_WAIT_V = STARVE_W'(MAX_WAIT);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    // Grant frozen while a request is offered but not yet accepted, so the
    // payload seen by memory cannot change mid-handshake.
    arb_owner_t lock_q, lock_d;
    arb_owner_t grant;

    logic [STARVE_W-1:0] starve_cnt;
    logic                xfer;
    logic                rsp_hit;

    // ---------------- grant selection (IDLE only) ----------------
    always_comb begin
        grant = OWN_NONE;
        if (lock_q != OWN_NONE) begin
            grant = lock_q;
        end else if (d_req_valid && (starve_cnt < MAX_WAIT_V)) begin
            grant = OWN_D;
        end else if (if_req_valid) begin
            grant = OWN_IF;
        end else if (d_req_valid) begin
            grant = OWN_D;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            lock_q  <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
        end
    end

    // ---------------- next state and outputs ----------------
    // NOTE: every signal gets a default first so no path through this block
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        lock_d        = lock_q;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;

        // Request side is gated by reset_n so the handshake outputs read 0
        // while reset is held, whatever the requesters drive.
        if ((state_q == IDLE) && reset_n) begin
            unique case (grant)
                OWN_IF: begin
                    mem_req_valid = if_req_valid;
                    mem_addr      = if_addr;
                    if_req_ready  = mem_req_ready;
                end
                OWN_D: begin
                    mem_req_valid = d_req_valid;
                    mem_addr      = d_addr;
                    mem_we        = d_we;
                    mem_wdata     = d_wdata;
                    d_req_ready   = mem_req_ready;
                end
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (mem_req_valid && mem_req_ready) begin
                    state_d = WAIT_RSP;
                    owner_d = grant;
                    lock_d  = OWN_NONE;
                end else if (mem_req_valid) begin
                    lock_d  = grant;
                end else begin
                    lock_d  = OWN_NONE;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign xfer    = mem_req_valid && mem_req_ready;
    assign rsp_hit = (state_q == WAIT_RSP) && mem_rsp_valid;

    // Responses are routed to the owner only; late/spurious memory responses
    // in IDLE never reach a requester. Read data is zero outside the pulse.
    assign if_rsp_valid = rsp_hit && (owner_q == OWN_IF);
    assign d_rsp_valid  = rsp_hit && (owner_q == OWN_D);
    assign if_rdata     = if_rsp_valid ? mem_rdata : '0;
    assign d_rdata      = d_rsp_valid  ? mem_rdata : '0;

    // ---------------- fetch starvation counter ----------------
    // Counts data wins while fetch was waiting; any fetch transfer clears it.
    sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (xfer && (grant == OWN_D) && if_req_valid),
        .clr     (xfer && (grant == OWN_IF)),
        .count   (starve_cnt)
    );

`ifdef MEM_ARB_PERF_EN
    // ---------------- performance counters ----------------
    logic stall;
    assign stall = (if_req_valid && !if_req_ready) || (d_req_valid && !d_req_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_if_grants    <= '0;
            perf_d_grants     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (xfer && (grant == OWN_IF)) perf_if_grants <= perf_if_grants + 32'd1;
            if (xfer && (grant == OWN_D))  perf_d_grants  <= perf_d_grants + 32'd1;
            if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. Requester drivers push expected
//   response data into per-channel queues when a request is presented; a
//   monitor pops and compares on every response pulse and logs each memory
//   transfer (owner, address, payload, cycle) for directed checks.
//   Build with MEM_ARB_PERF_EN defined to also check the perf counters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              if_req_valid = 1'b0;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req_valid = 1'b0;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              d_we = 1'b0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_addr        (d_addr),
        .d_we          (d_we),
        .d_wdata       (d_wdata),
        .d_rsp_valid   (d_rsp_valid),
        .d_rdata       (d_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants    (perf_if_grants),
        .perf_d_grants     (perf_d_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory contents model
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    typedef struct {
        logic        is_store;
        logic [31:0] data;
    } d_exp_t;

    typedef struct {
        logic [1:0]  owner;   // {d_req_ready, if_req_ready}: 1 = IF, 2 = D
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
    } xfer_t;

    logic [31:0] exp_if_q[$];
    d_exp_t      exp_d_q[$];
    xfer_t       xfer_q[$];
    int          if_rsp_cyc_q[$];

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    int          if_rsp_cnt = 0;
    int          d_rsp_cnt = 0;
    xfer_t       mon_x;
    logic [31:0] mon_e;
    d_exp_t      mon_de;

    always @(negedge clk) begin
        cyc++;
        if (mem_req_valid && mem_req_ready) begin
            mon_x.owner = {d_req_ready, if_req_ready};
            mon_x.addr  = mem_addr;
            mon_x.we    = mem_we;
            mon_x.wdata = mem_wdata;
            mon_x.cyc   = cyc;
            xfer_q.push_back(mon_x);
        end
        if (if_rsp_valid) begin
            if_rsp_cnt++;
            if_rsp_cyc_q.push_back(cyc);
            if (exp_if_q.size() == 0) begin
                check("if_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_if_q.pop_front();
                check("if_rdata", if_rdata, mon_e);
            end
        end
        if (d_rsp_valid) begin
            d_rsp_cnt++;
            if (exp_d_q.size() == 0) begin
                check("d_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_de = exp_d_q.pop_front();
                if (!mon_de.is_store) check("d_rdata", d_rdata, mon_de.data);
            end
        end
    end

    // ---------------- memory responder ----------------
    logic        auto_rsp = 1'b0;
    logic        tst_rsp_valid = 1'b1;
    logic [31:0] tst_rdata = 32'h1234_5678;
    logic        rsp_xfer;
    logic [31:0] rsp_addr;

    always begin
        @(negedge clk);
        rsp_xfer = mem_req_valid && mem_req_ready;
        rsp_addr = mem_addr;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            mem_rsp_valid = rsp_xfer;
            mem_rdata     = rsp_xfer ? mem_fn(rsp_addr) : 32'h0;
        end else begin
            mem_rsp_valid = tst_rsp_valid;
            mem_rdata     = tst_rdata;
        end
    end

    // ---------------- requester drivers ----------------
    int          if_todo = 0;
    int          d_todo = 0;
    logic [31:0] if_next = 32'h0;
    logic [31:0] d_next = 32'h0;
    logic        d_store = 1'b0;
    logic [31:0] d_wdata_next = 32'h0;
    logic        if_fire, d_fire;
    d_exp_t      drv_de;

    always begin
        @(negedge clk);
        if_fire = if_req_valid && if_req_ready;
        @(posedge clk);
        #1;
        if (if_fire) if_req_valid = 1'b0;
        if (!if_req_valid && (if_todo > 0)) begin
            if_req_valid = 1'b1;
            if_addr      = if_next;
            exp_if_q.push_back(mem_fn(if_next));
            if_next      = if_next + 32'd4;
            if_todo--;
        end
    end

    always begin
        @(negedge clk);
        d_fire = d_req_valid && d_req_ready;
        @(posedge clk);
        #1;
        if (d_fire) d_req_valid = 1'b0;
        if (!d_req_valid && (d_todo > 0)) begin
            d_req_valid     = 1'b1;
            d_addr          = d_next;
            d_we            = d_store;
            d_wdata         = d_wdata_next;
            drv_de.is_store = d_store;
            drv_de.data     = mem_fn(d_next);
            exp_d_q.push_back(drv_de);
            d_next          = d_next + 32'd4;
            d_todo--;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input int budget);
        int n = 0;
        while ((if_todo > 0 || d_todo > 0 || if_req_valid || d_req_valid ||
                exp_if_q.size() > 0 || exp_d_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    int          n_if0;
    int          n_d0;
    int          wait_n;
    logic [1:0]  order[10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    initial begin
        // Reset with hostile inputs: both requesters valid, memory ready and
        // a memory response asserted. Everything must read 0.
        if_next = 32'h40;
        d_next  = 32'h80;
        if_todo = 1;
        d_todo  = 1;
        repeat (3) @(negedge clk);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_if_req_ready", if_req_ready, 0);
        check("rst_d_req_ready", d_req_ready, 0);
        check("rst_if_rsp_valid", if_rsp_valid, 0);
        check("rst_d_rsp_valid", d_rsp_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        tst_rsp_valid = 1'b0;
        auto_rsp      = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_done(100);

        // Fetch only: address forwarding, 1-cycle response, 1-cycle bubble.
        @(negedge clk);
        xfer_q.delete();
        if_rsp_cyc_q.delete();
        if_next = 32'h10;
        if_todo = 2;
        wait_done(100);
        check("fetch_xfer_count", xfer_q.size(), 2);
        check("fetch_addr0", xfer_q[0].addr, 32'h10);
        check("fetch_we0", xfer_q[0].we, 0);
        check("fetch_owner0", xfer_q[0].owner, 1);
        check("fetch_addr1", xfer_q[1].addr, 32'h14);
        check("fetch_rsp_latency", if_rsp_cyc_q[0], xfer_q[0].cyc + 1);
        check("fetch_next_grant", xfer_q[1].cyc, if_rsp_cyc_q[0] + 1);

        // Both valid continuously: data wins MAX_WAIT times, then fetch.
        do_reset();
        xfer_q.delete();
        if_next = 32'h200;
        d_next  = 32'h300;
        if_todo = 2;
        d_todo  = 8;
        wait_done(300);
        check("prio_xfer_count", xfer_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("prio_owner%0d", i), xfer_q[i].owner, order[i]);
        end

        // Store: payload forwarded, ack on data channel only.
        xfer_q.delete();
        n_if0        = if_rsp_cnt;
        n_d0         = d_rsp_cnt;
        d_next       = 32'h100;
        d_wdata_next = 32'hDEAD_BEEF;
        d_store      = 1'b1;
        d_todo       = 1;
        wait_done(100);
        d_store      = 1'b0;
        check("store_addr", xfer_q[0].addr, 32'h100);
        check("store_we", xfer_q[0].we, 1);
        check("store_wdata", xfer_q[0].wdata, 32'hDEAD_BEEF);
        check("store_owner", xfer_q[0].owner, 2);
        check("store_ack", d_rsp_cnt - n_d0, 1);
        check("store_no_if_rsp", if_rsp_cnt - n_if0, 0);

        // Memory back-pressure with data waiting, fetch raised later.
        xfer_q.delete();
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        d_next       = 32'h400;
        d_wdata_next = 32'h0;
        d_todo       = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), mem_req_valid, 1);
            check($sformatf("bp_d_ready%0d", i), d_req_ready, 0);
            check($sformatf("bp_addr%0d", i), mem_addr, 32'h400);
        end
        if_next = 32'h500;
        if_todo = 1;
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        @(negedge clk);
        check("bp_d_ready_c4", d_req_ready, 1);
        check("bp_if_ready_c4", if_req_ready, 0);
        check("bp_addr_c4", mem_addr, 32'h400);
        @(negedge clk);
        check("bp_d_ready_c5", d_req_ready, 0);
        wait_done(100);
        check("bp_owner0", xfer_q[0].owner, 2);
        check("bp_owner1", xfer_q[1].owner, 1);

        // Fetch offered first under back-pressure: grant must not switch to data.
        xfer_q.delete();
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        if_next = 32'h600;
        if_todo = 1;
        @(negedge clk);
        @(negedge clk);
        check("lock_addr_if", mem_addr, 32'h600);
        d_next = 32'h700;
        d_todo = 1;
        @(negedge clk);
        @(negedge clk);
        check("lock_addr_held", mem_addr, 32'h600);
        check("lock_d_ready", d_req_ready, 0);
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        @(negedge clk);
        check("lock_if_ready", if_req_ready, 1);
        check("lock_d_ready2", d_req_ready, 0);
        wait_done(100);
        check("lock_owner0", xfer_q[0].owner, 1);
        check("lock_owner1", xfer_q[1].owner, 2);

        // Reset while waiting for a response; the late response is dropped.
        xfer_q.delete();
        auto_rsp      = 1'b0;
        tst_rsp_valid = 1'b0;
        d_next        = 32'h800;
        d_todo        = 1;
        wait_n        = 0;
        while (xfer_q.size() == 0 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("rst_mid_xfer_seen", 32'(wait_n < 50), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        exp_d_q.delete();
        @(negedge clk);
        check("rst_mid_req_valid", mem_req_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        tst_rsp_valid = 1'b1;
        tst_rdata     = 32'hCAFE_F00D;
        @(negedge clk);
        check("late_d_rsp_valid", d_rsp_valid, 0);
        check("late_if_rsp_valid", if_rsp_valid, 0);
        check("late_d_rdata", d_rdata, 0);
        check("late_if_rdata", if_rdata, 0);
        check("late_mem_req_valid", mem_req_valid, 0);
        tst_rsp_valid = 1'b0;
        auto_rsp      = 1'b1;
        @(negedge clk);
        n_if0   = if_rsp_cnt;
        if_next = 32'h900;
        if_todo = 1;
        wait_done(100);
        check("recover_fetch", if_rsp_cnt - n_if0, 1);

`ifdef MEM_ARB_PERF_EN
        do_reset();
        if_next = 32'hA00;
        d_next  = 32'hB00;
        if_todo = 5;
        d_todo  = 3;
        wait_done(300);
        check("perf_if_grants", perf_if_grants, 5);
        check("perf_d_grants", perf_d_grants, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
